// File: rtl/instr_realigner_pkg.sv
// Shared frontend definitions for the instruction realigner: FSM state
// encoding, the held-halfword record and the 32-bit instruction tag.
package instr_realigner_pkg;

  // Widest address the held-halfword record can carry; instances use VLEN <= this.
  localparam int REALIGN_ADDR_W = 64;

  // Low two bits of a halfword that starts a 32-bit instruction.
  localparam logic [1:0] INSTR_32B_TAG = 2'b11;

  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_HALF_PART = 2'd1,
    S_HALF_COMP = 2'd2
  } realign_state_e;

  typedef struct packed {
    logic [15:0]               data;
    logic [REALIGN_ADDR_W-1:0] addr;
  } held_half_t;

  // A halfword is a complete compressed instruction unless it carries the 32-bit tag.
  function automatic logic is_compressed_half(input logic [15:0] half);
    return half[1:0] != INSTR_32B_TAG;
  endfunction

endpackage

// File: rtl/instr_realigner.sv
// Instruction realigner: turns word-aligned 32-bit fetch data holding a mix
// of 16-bit and 32-bit instructions into one instruction per handshake.
// One leftover halfword is carried between fetch words, so 32-bit
// instructions may straddle two words and jumps may land mid-word.
// Optional build macro INSTR_REALIGNER_PERF_CNT_EN adds straddle_cnt_o and
// compressed_cnt_o event counters.
module instr_realigner
  import instr_realigner_pkg::*;
#(
  parameter int VLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic [31:0]     fetch_data_i,
  input  logic [VLEN-1:0] fetch_addr_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  output logic [31:0]     instr_o,
  output logic [VLEN-1:0] instr_addr_o,
  output logic            is_compressed_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i
`ifdef INSTR_REALIGNER_PERF_CNT_EN
  ,
  output logic [31:0]     straddle_cnt_o,
  output logic [31:0]     compressed_cnt_o
`endif
);

  realign_state_e  state_reg, state_next;
  held_half_t      held_reg, held_next;

  logic            slot_free;
  logic [15:0]     fetch_lo;
  logic [15:0]     fetch_hi;
  logic            lo_comp;
  logic            hi_comp;
  logic [VLEN-1:0] fetch_hi_addr;
  logic [VLEN-1:0] held_addr;

  logic            emit_valid;
  logic [31:0]     emit_data;
  logic [VLEN-1:0] emit_addr;
  logic            emit_comp;

  // Split the fetch word and precompute the upper-halfword address (wraps mod 2^VLEN).
  always_comb begin
    slot_free     = !instr_valid_o || instr_ready_i;
    fetch_lo      = fetch_data_i[15:0];
    fetch_hi      = fetch_data_i[31:16];
    lo_comp       = is_compressed_half(fetch_lo);
    hi_comp       = is_compressed_half(fetch_hi);
    fetch_hi_addr = {fetch_addr_i[VLEN-1:2], 2'b00} + VLEN'(2);
    held_addr     = held_reg.addr[VLEN-1:0];
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: flush wins, otherwise advance only when the output slot can take data.
  always_comb begin
    state_next = state_reg;
    if (flush_i) begin
      state_next = S_EMPTY;
    end else if (slot_free) begin
      unique case (state_reg)
        S_HALF_COMP: begin
          state_next = S_EMPTY;
        end
        S_EMPTY: begin
          if (fetch_valid_i) begin
            if (fetch_addr_i[1]) begin
              state_next = hi_comp ? S_EMPTY : S_HALF_PART;
            end else if (!lo_comp) begin
              state_next = S_EMPTY;
            end else begin
              state_next = hi_comp ? S_HALF_COMP : S_HALF_PART;
            end
          end
        end
        S_HALF_PART: begin
          if (fetch_valid_i) begin
            state_next = hi_comp ? S_HALF_COMP : S_HALF_PART;
          end
        end
        default: begin
          state_next = S_EMPTY;
        end
      endcase
    end
  end

  // Output logic: fetch handshake, the instruction to emit and the halfword to carry over.
  always_comb begin
    fetch_ready_o = 1'b0;
    emit_valid    = 1'b0;
    emit_data     = '0;
    emit_addr     = '0;
    held_next     = held_reg;
    if (flush_i) begin
      held_next = '0;
    end else if (slot_free) begin
      unique case (state_reg)
        S_HALF_COMP: begin
          emit_valid = 1'b1;
          emit_data  = {16'b0, held_reg.data};
          emit_addr  = held_addr;
        end
        S_EMPTY: begin
          if (fetch_valid_i) begin
            fetch_ready_o = 1'b1;
            if (fetch_addr_i[1]) begin
              // Jump into the upper halfword: the lower halfword is not part of the stream.
              if (hi_comp) begin
                emit_valid = 1'b1;
                emit_data  = {16'b0, fetch_hi};
                emit_addr  = fetch_hi_addr;
              end else begin
                held_next.data = fetch_hi;
                held_next.addr = REALIGN_ADDR_W'(fetch_hi_addr);
              end
            end else if (!lo_comp) begin
              emit_valid = 1'b1;
              emit_data  = fetch_data_i;
              emit_addr  = fetch_addr_i;
            end else begin
              emit_valid     = 1'b1;
              emit_data      = {16'b0, fetch_lo};
              emit_addr      = fetch_addr_i;
              held_next.data = fetch_hi;
              held_next.addr = REALIGN_ADDR_W'(fetch_hi_addr);
            end
          end
        end
        S_HALF_PART: begin
          if (fetch_valid_i) begin
            // Held halfword is the low half; the new lower halfword completes it.
            fetch_ready_o  = 1'b1;
            emit_valid     = 1'b1;
            emit_data      = {fetch_lo, held_reg.data};
            emit_addr      = held_addr;
            held_next.data = fetch_hi;
            held_next.addr = REALIGN_ADDR_W'(fetch_hi_addr);
          end
        end
        default: begin
        end
      endcase
    end
    emit_comp = emit_data[1:0] != INSTR_32B_TAG;
  end

  // Held halfword register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_reg <= '0;
    end else begin
      held_reg <= held_next;
    end
  end

  // Output register: payload is frozen while the downstream stalls; flush drops it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_o         <= '0;
      instr_addr_o    <= '0;
      is_compressed_o <= 1'b0;
      instr_valid_o   <= 1'b0;
    end else if (flush_i) begin
      instr_valid_o <= 1'b0;
    end else if (slot_free) begin
      instr_valid_o <= emit_valid;
      if (emit_valid) begin
        instr_o         <= emit_data;
        instr_addr_o    <= emit_addr;
        is_compressed_o <= emit_comp;
      end
    end
  end

`ifdef INSTR_REALIGNER_PERF_CNT_EN
  logic emit_fire;
  logic emit_straddle;

  always_comb begin
    emit_fire     = emit_valid && slot_free && !flush_i;
    emit_straddle = emit_fire && (state_reg == S_HALF_PART);
  end

  // Event counters: free-running, wrap at 2^32, not cleared by flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      straddle_cnt_o   <= '0;
      compressed_cnt_o <= '0;
    end else begin
      if (emit_straddle) begin
        straddle_cnt_o <= straddle_cnt_o + 32'd1;
      end
      if (emit_fire && emit_comp) begin
        compressed_cnt_o <= compressed_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_realigner.sv
// Scoreboard bench for instr_realigner: directed fetch words push their
// hand-computed instructions into a queue; a monitor pops on each output handshake.
module tb_instr_realigner;

  localparam int VLEN = 64;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [31:0]     fetch_data;
  logic [VLEN-1:0] fetch_addr;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [31:0]     instr;
  logic [VLEN-1:0] instr_addr;
  logic            is_comp;
  logic            instr_valid;
  logic            instr_ready;
`ifdef INSTR_REALIGNER_PERF_CNT_EN
  logic [31:0]     straddle_cnt;
  logic [31:0]     compressed_cnt;
`endif

  typedef struct {
    logic [31:0]     instr;
    logic [VLEN-1:0] addr;
    logic            comp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  instr_realigner #(.VLEN(VLEN)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .fetch_data_i    (fetch_data),
    .fetch_addr_i    (fetch_addr),
    .fetch_valid_i   (fetch_valid),
    .fetch_ready_o   (fetch_ready),
    .instr_o         (instr),
    .instr_addr_o    (instr_addr),
    .is_compressed_o (is_comp),
    .instr_valid_o   (instr_valid),
    .instr_ready_i   (instr_ready)
`ifdef INSTR_REALIGNER_PERF_CNT_EN
    ,
    .straddle_cnt_o  (straddle_cnt),
    .compressed_cnt_o(compressed_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_instr(input logic [31:0] i, input logic [VLEN-1:0] a, input logic c);
    exp_t e;
    e.instr = i;
    e.addr  = a;
    e.comp  = c;
    sb.push_back(e);
  endtask

  // Wait (bounded) until the presented fetch word is taken, then drop fetch_valid.
  task automatic wait_consume(output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if (fetch_ready) break;
      waited++;
      if (waited > 50) begin
        errors++;
        $display("FAIL fetch_timeout: got no fetch_ready, expected consumption of 0x%0h", fetch_data);
        break;
      end
    end
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [VLEN-1:0] a, output int waited);
    fetch_data  = d;
    fetch_addr  = a;
    fetch_valid = 1'b1;
    wait_consume(waited);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the oldest expected instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && instr_ready) begin
        $display("out instr=0x%08h addr=0x%0h comp=%0b", instr, instr_addr, is_comp);
        if (sb.size() == 0) begin
          check("unexpected_output", {32'b0, instr}, 64'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          check("instr", {32'b0, instr}, {32'b0, e.instr});
          check("instr_addr", instr_addr, e.addr);
          check("is_compressed", {63'b0, is_comp}, {63'b0, e.comp});
        end
      end
    end
  end

  initial begin
    int w;
    rst_n       = 1'b0;
    flush       = 1'b0;
    fetch_data  = '0;
    fetch_addr  = '0;
    fetch_valid = 1'b0;
    instr_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", {63'b0, instr_valid}, 64'd0);
    check("rst_instr", {32'b0, instr}, 64'd0);
    check("rst_addr", instr_addr, 64'd0);
    check("rst_comp", {63'b0, is_comp}, 64'd0);
    check("rst_fetch_ready", {63'b0, fetch_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Aligned 32-bit word
    expect_instr(32'h0000_0013, 64'h1000, 1'b0);
    send_word(32'h0000_0013, 64'h1000, w);
    check("w32_wait", 64'(w), 64'd0);
    idle(3);

    // Two compressed in one word, then a back-to-back word stalls one cycle
    expect_instr(32'h0000_0001, 64'h1000, 1'b1);
    expect_instr(32'h0000_0001, 64'h1002, 1'b1);
    expect_instr(32'h0000_0013, 64'h1004, 1'b0);
    send_word(32'h0001_0001, 64'h1000, w);
    check("cc_wait", 64'(w), 64'd0);
    send_word(32'h0000_0013, 64'h1004, w);
    check("after_cc_wait", 64'(w), 64'd1);
    idle(3);

    // Straddling 32-bit instruction
    expect_instr(32'h0000_0001, 64'h1000, 1'b1);
    expect_instr(32'h0000_0013, 64'h1002, 1'b0);
    expect_instr(32'h0000_0001, 64'h1006, 1'b1);
    send_word(32'h0013_0001, 64'h1000, w);
    send_word(32'h0001_0000, 64'h1004, w);
    check("straddle_wait", 64'(w), 64'd0);
    idle(3);

    // Jump onto the upper halfword
    expect_instr(32'h0000_0001, 64'h1002, 1'b1);
    send_word(32'h0001_0013, 64'h1002, w);
    idle(3);

    // Top of address space, then straddle across the wrap
    expect_instr(32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    expect_instr(32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    send_word(32'h0001_0001, 64'hFFFF_FFFF_FFFF_FFFC, w);
    idle(3);
    expect_instr(32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    expect_instr(32'h0000_0001, 64'h2, 1'b1);
    send_word(32'h0013_0000, 64'hFFFF_FFFF_FFFF_FFFE, w);
    send_word(32'h0001_0000, 64'h0, w);
    idle(3);

    // Downstream stall for 3 cycles
    instr_ready = 1'b0;
    expect_instr(32'h0000_0013, 64'h3000, 1'b0);
    expect_instr(32'h0000_0033, 64'h3004, 1'b0);
    send_word(32'h0000_0013, 64'h3000, w);
    fetch_data  = 32'h0000_0033;
    fetch_addr  = 64'h3004;
    fetch_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {63'b0, instr_valid}, 64'd1);
      check("stall_instr", {32'b0, instr}, 64'h13);
      check("stall_addr", instr_addr, 64'h3000);
      check("stall_fetch_ready", {63'b0, fetch_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    wait_consume(w);
    check("release_wait", 64'(w), 64'd0);
    idle(3);

    // Flush while holding the low half of a 32-bit instruction
    send_word(32'h0013_0000, 64'h2002, w);
    fetch_data  = 32'h0000_0013;
    fetch_addr  = 64'h2000;
    fetch_valid = 1'b1;
    flush       = 1'b1;
    @(negedge clk);
    check("flush_fetch_ready", {63'b0, fetch_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", {63'b0, instr_valid}, 64'd0);
    @(posedge clk);
    #1;
    expect_instr(32'h0000_0013, 64'h2000, 1'b0);
    send_word(32'h0000_0013, 64'h2000, w);
    idle(5);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
